// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// ALU initiator: decodes ALUOp/funct requests, drives the ALU and returns a registered response.
// MULTU is built from 32 shift-and-add passes through the ALU adder.
module alu_op_sequencer #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [4:0]       req_shamt,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_AND  = 4'b0010;
  localparam logic [3:0] CTRL_OR   = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SLT  = 4'b0110;
  localparam logic [3:0] CTRL_PASS = 4'b1111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  localparam logic [4:0] LAST_COUNT = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]       dec_ctrl;
  logic [WIDTH-1:0] dec_in1;
  logic [WIDTH-1:0] dec_in2;
  logic             dec_illegal;
  logic             dec_mul;

  // In MUL, op1_reg is the accumulator and op2_reg the shifting multiplicand.
  logic [3:0]       ctrl_reg;
  logic [WIDTH-1:0] op1_reg;
  logic [WIDTH-1:0] op2_reg;
  logic             illegal_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [4:0]       count_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             rsp_illegal_reg;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    dec_ctrl    = CTRL_PASS;
    dec_in1     = req_a;
    dec_in2     = req_b;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    case (req_aluop)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_PASS;
      default: begin
        case (req_funct)
          FN_ADD: dec_ctrl = CTRL_ADD;
          FN_SUB: dec_ctrl = CTRL_SUB;
          FN_AND: dec_ctrl = CTRL_AND;
          FN_OR:  dec_ctrl = CTRL_OR;
          FN_SLT: dec_ctrl = CTRL_SLT;
          FN_SLL: begin
            // The ALU shifts in2 left by in1.
            dec_ctrl = CTRL_SLL;
            dec_in1  = WIDTH'(req_shamt);
            dec_in2  = req_b;
          end
          FN_SRL: begin
            dec_ctrl = CTRL_SRL;
            dec_in1  = req_b;
            dec_in2  = WIDTH'(req_shamt);
          end
          FN_MULTU: begin
            if (MUL_EN) begin
              dec_ctrl = CTRL_ADD;
              dec_mul  = 1'b1;
            end else begin
              dec_ctrl    = CTRL_PASS;
              dec_illegal = 1'b1;
            end
          end
          default: begin
            dec_ctrl    = CTRL_PASS;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign acc_next = mplier_reg[0] ? alu_out : op1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = dec_mul ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_RESP;
      ST_MUL: begin
        if (count_reg == LAST_COUNT) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg        <= CTRL_PASS;
      op1_reg         <= '0;
      op2_reg         <= '0;
      illegal_reg     <= 1'b0;
      mplier_reg      <= '0;
      count_reg       <= '0;
      result_reg      <= '0;
      zero_reg        <= 1'b0;
      rsp_illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            ctrl_reg    <= dec_ctrl;
            illegal_reg <= dec_illegal;
            count_reg   <= '0;
            if (dec_mul) begin
              op1_reg    <= '0;
              op2_reg    <= req_a;
              mplier_reg <= req_b;
            end else begin
              op1_reg    <= dec_in1;
              op2_reg    <= dec_in2;
              mplier_reg <= '0;
            end
          end
        end
        ST_EXEC: begin
          result_reg      <= alu_out;
          zero_reg        <= alu_zero;
          rsp_illegal_reg <= illegal_reg;
        end
        ST_MUL: begin
          op1_reg    <= acc_next;
          op2_reg    <= op2_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 5'd1;
          if (count_reg == LAST_COUNT) begin
            result_reg      <= acc_next;
            zero_reg        <= (acc_next == '0);
            rsp_illegal_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    req_ready = (state_reg == ST_IDLE);
    rsp_valid = (state_reg == ST_RESP);
    alu_ctrl  = CTRL_PASS;
    alu_in1   = '0;
    alu_in2   = '0;
    case (state_reg)
      ST_EXEC: begin
        alu_ctrl = ctrl_reg;
        alu_in1  = op1_reg;
        alu_in2  = op2_reg;
      end
      ST_MUL: begin
        alu_ctrl = CTRL_ADD;
        alu_in1  = op1_reg;
        alu_in2  = op2_reg;
      end
      default: begin
      end
    endcase
  end

  assign rsp_result  = result_reg;
  assign rsp_zero    = zero_reg;
  assign rsp_illegal = rsp_illegal_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// Bench for alu_op_sequencer: behavioural ALU, cycle-level reference model with a
// per-cycle compare process, and directed transactions with hand-computed results.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid0;
  logic        req_ready, req_ready0;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_shamt;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;
  logic [31:0] alu_in1_0, alu_in2_0, alu_out_0;
  logic [3:0]  alu_ctrl_0;
  logic        alu_zero_0;
  logic        rsp_valid0, rsp_ready0;
  logic [31:0] rsp_result0;
  logic        rsp_zero0, rsp_illegal0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  alu_op_sequencer #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_in1(alu_in1_0), .alu_in2(alu_in2_0), .alu_ctrl(alu_ctrl_0),
    .alu_out(alu_out_0), .alu_zero(alu_zero_0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_result(rsp_result0), .rsp_zero(rsp_zero0), .rsp_illegal(rsp_illegal0)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x1, input logic [31:0] x2);
    case (c)
      4'b0000: return x1 + x2;
      4'b0001: return x1 - x2;
      4'b0010: return x1 & x2;
      4'b0011: return x1 | x2;
      4'b0100: return x2 << x1;
      4'b0101: return x1 >> x2;
      4'b0110: return (x1 < x2) ? 32'd1 : 32'd0;
      default: return x2;
    endcase
  endfunction

  assign alu_out    = alu_f(alu_ctrl, alu_in1, alu_in2);
  assign alu_zero   = (alu_in1 == alu_in2);
  assign alu_out_0  = alu_f(alu_ctrl_0, alu_in1_0, alu_in2_0);
  assign alu_zero_0 = (alu_in1_0 == alu_in2_0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference decode: ALU operands the request should produce and the result it must yield.
  task automatic model_decode(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] sh,
                              output logic [3:0] c, output logic [31:0] x1, output logic [31:0] x2,
                              output logic [31:0] res, output bit z, output bit il, output bit mul);
    c = 4'hF; x1 = a; x2 = b; res = b; il = 1'b0; mul = 1'b0;
    case (op)
      2'b00: begin c = 4'h0; res = a + b; end
      2'b01: begin c = 4'h1; res = a - b; end
      2'b11: ;
      default: begin
        case (fn)
          6'b100000: begin c = 4'h0; res = a + b; end
          6'b100010: begin c = 4'h1; res = a - b; end
          6'b100100: begin c = 4'h2; res = a & b; end
          6'b100101: begin c = 4'h3; res = a | b; end
          6'b101010: begin c = 4'h6; res = (a < b) ? 32'd1 : 32'd0; end
          6'b000000: begin c = 4'h4; x1 = {27'd0, sh}; res = b << sh; end
          6'b000010: begin c = 4'h5; x1 = b; x2 = {27'd0, sh}; res = b >> sh; end
          6'b011001: begin c = 4'h0; mul = 1'b1; res = a * b; end
          default: il = 1'b1;
        endcase
      end
    endcase
    z = mul ? (res == 32'd0) : (x1 == x2);
  endtask

  bit          started = 1'b0;
  bit          busy = 1'b0;
  int          t = 0;
  int          lat = 1;
  logic [3:0]  m_c;
  logic [31:0] m_x1, m_x2, m_res, m_a, m_b;
  bit          m_z, m_il, m_mul;

  always @(posedge clk) begin : model
    logic [3:0]  c;
    logic [31:0] x1, x2, res;
    bit          z, il, mul;
    if (reset) begin
      started <= 1'b1;
      busy    <= 1'b0;
      t       <= 0;
    end else if (started) begin
      if (!busy) begin
        if (req_valid) begin
          model_decode(req_aluop, req_funct, req_a, req_b, req_shamt, c, x1, x2, res, z, il, mul);
          busy <= 1'b1; t <= 0; lat <= mul ? 32 : 1;
          m_c <= c; m_x1 <= x1; m_x2 <= x2; m_res <= res;
          m_z <= z; m_il <= il; m_mul <= mul; m_a <= req_a; m_b <= req_b;
        end
      end else if (t >= lat) begin
        if (rsp_ready) busy <= 1'b0;
      end else begin
        t <= t + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [63:0] mask;
    if (started) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      if (busy && t >= lat) begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_z});
        chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, m_il});
      end else begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      if (busy && t < lat) begin
        if (m_mul) begin
          mask = (64'd1 << t) - 64'd1;
          chk("mul_ctrl", {28'd0, alu_ctrl}, 32'd0);
          chk("mul_acc", alu_in1, m_a * (m_b & mask[31:0]));
          chk("mul_mcand", alu_in2, m_a << t);
        end else begin
          chk("exec_ctrl", {28'd0, alu_ctrl}, {28'd0, m_c});
          chk("exec_in1", alu_in1, m_x1);
          chk("exec_in2", alu_in2, m_x2);
        end
      end else begin
        chk("idle_ctrl", {28'd0, alu_ctrl}, 32'hF);
        chk("idle_in1", alu_in1, 32'd0);
        chk("idle_in2", alu_in2, 32'd0);
      end
    end
  end

  // Called #1 after an edge with the sequencer idle; e_lat counts edges from the drive.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] e_res, input bit e_z, input bit e_il, input int e_lat,
                        input int hold, input bit chk_exec, input logic [3:0] e_c,
                        input logic [31:0] e_x1, input logic [31:0] e_x2);
    int  n;
    bit  seen;
    req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_shamt = sh;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (chk_exec) begin
      chk({nm, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e_c});
      chk({nm, "_in1"}, alu_in1, e_x1);
      chk({nm, "_in2"}, alu_in2, e_x2);
    end
    n = 1;
    seen = rsp_valid;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      seen = rsp_valid;
    end
    chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
    chk({nm, "_latency"}, n, e_lat);
    chk({nm, "_result"}, rsp_result, e_res);
    chk({nm, "_zero"}, {31'd0, rsp_zero}, {31'd0, e_z});
    chk({nm, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, e_il});
    $display("op %s: result %h zero %0d illegal %0d latency %0d", nm, rsp_result, rsp_zero, rsp_illegal, n);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a = 32'hDEAD_0000 + i;
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_hold_result"}, rsp_result, e_res);
      chk({nm, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_release"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin : main
    int  n;
    bit  seen;
    reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b1; rsp_ready0 = 1'b1;
    req_aluop = 2'b00; req_funct = 6'd0; req_a = 32'd0; req_b = 32'd0; req_shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'hF);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);

    //      name     op     funct      a             b             sh  result        z  il lat hold exec ctrl  in1       in2
    run_op("add",    2'b10, 6'b100000, 32'd7,        32'd5,        5'd0, 32'd12,     0, 0, 2,  0, 1, 4'h0, 32'd7,    32'd5);
    run_op("sub_eq", 2'b01, 6'b000000, 32'h1234,     32'h1234,     5'd0, 32'd0,      1, 0, 2,  0, 1, 4'h1, 32'h1234, 32'h1234);
    run_op("sll",    2'b10, 6'b000000, 32'h99,       32'h1,        5'd4, 32'h10,     0, 0, 2,  0, 1, 4'h4, 32'd4,    32'd1);
    run_op("srl",    2'b10, 6'b000010, 32'h99,       32'h80,       5'd3, 32'h10,     0, 0, 2,  0, 1, 4'h5, 32'h80,   32'd3);
    run_op("and",    2'b10, 6'b100100, 32'hF0F0,     32'hFF00,     5'd0, 32'hF000,   0, 0, 2,  0, 1, 4'h2, 32'hF0F0, 32'hFF00);
    run_op("or",     2'b10, 6'b100101, 32'hF0F0,     32'hFF00,     5'd0, 32'hFFF0,   0, 0, 2,  0, 0, 4'h3, 32'd0,    32'd0);
    run_op("slt_lt", 2'b10, 6'b101010, 32'd3,        32'd5,        5'd0, 32'd1,      0, 0, 2,  0, 1, 4'h6, 32'd3,    32'd5);
    run_op("slt_ge", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd5,        5'd0, 32'd0,      0, 0, 2,  0, 0, 4'h6, 32'd0,    32'd0);
    run_op("pass",   2'b11, 6'b100000, 32'd1,        32'hABCD,     5'd0, 32'hABCD,   0, 0, 2,  0, 1, 4'hF, 32'd1,    32'hABCD);
    run_op("illeg",  2'b10, 6'b111111, 32'd3,        32'h55,       5'd0, 32'h55,     0, 1, 2,  0, 1, 4'hF, 32'd3,    32'h55);
    run_op("addwrap",2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,      0, 0, 2,  0, 0, 4'h0, 32'd0,    32'd0);
    run_op("mul_a",  2'b10, 6'b011001, 32'h10001,    32'h10001,    5'd0, 32'h20001,  0, 0, 33, 0, 1, 4'h0, 32'd0,    32'h10001);
    run_op("mul_b",  2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2,        5'd0, 32'hFFFFFFFE, 0, 0, 33, 0, 0, 4'h0, 32'd0,  32'd0);
    run_op("mul_z",  2'b10, 6'b011001, 32'd5,        32'd0,        5'd0, 32'd0,      1, 0, 33, 0, 0, 4'h0, 32'd0,    32'd0);
    run_op("hold",   2'b01, 6'b000000, 32'd100,      32'd58,       5'd0, 32'd42,     0, 0, 2,  5, 0, 4'h1, 32'd0,    32'd0);

    // Reset while MULTU is at count 10: the operation must vanish without a response.
    req_aluop = 2'b10; req_funct = 6'b011001; req_a = 32'd3; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    $display("op mid_mul_reset: dropped, ready %0d", req_ready);
    run_op("mul_after_rst", 2'b10, 6'b011001, 32'd6, 32'd7, 5'd0, 32'd42, 0, 0, 33, 0, 0, 4'h0, 32'd0, 32'd0);

    // Instance without the multiplier: MULTU is illegal and passes b.
    req_aluop = 2'b10; req_funct = 6'b011001; req_a = 32'd9; req_b = 32'h77; req_valid0 = 1'b1;
    @(posedge clk); #1 req_valid0 = 1'b0;
    chk("nomul_ctrl", {28'd0, alu_ctrl_0}, 32'hF);
    n = 1;
    seen = rsp_valid0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      seen = rsp_valid0;
    end
    chk("nomul_latency", n, 2);
    chk("nomul_result", rsp_result0, 32'h77);
    chk("nomul_illegal", {31'd0, rsp_illegal0}, 32'd1);
    $display("op nomul_multu: result %h illegal %0d latency %0d", rsp_result0, rsp_illegal0, n);
    @(posedge clk); #1;
    chk("nomul_release", {31'd0, rsp_valid0}, 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
